// File: rtl/text_pkg.sv
// Shared constants for the 80x30 text-mode display path: cell geometry,
// 640x480 timing totals and the fetch lead.
package text_pkg;

  localparam int COLS       = 80;
  localparam int ROWS       = 30;
  localparam int CHAR_W     = 8;
  localparam int CHAR_H     = 16;
  localparam int CELLS      = COLS * ROWS;
  localparam int CELL_AW    = 12;
  localparam int FONT_AW    = 11;

  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int H_TOTAL    = 800;
  localparam int V_TOTAL    = 525;
  localparam int FETCH_LEAD = 3;

  localparam int LINE_W     = $clog2(CHAR_H);

  // row*80 as (row<<6)+(row<<4); keeps a multiplier out of the fetch path.
  function automatic logic [CELL_AW-1:0] cell_index(input logic [4:0] row,
                                                    input logic [6:0] col);
    logic [CELL_AW-1:0] r;
    r = CELL_AW'(row);
    return (r << 6) + (r << 4) + CELL_AW'(col);
  endfunction

endpackage

// File: rtl/glyph_shifter.sv
// Pixel shift register for one glyph row: parallel load with inverse-video
// XOR, then shifts left one pixel per clock; msb is the current pixel.
module glyph_shifter
  import text_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [CHAR_W-1:0] data,
  input  logic              inverse,
  output logic              msb
);

  logic [CHAR_W-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset)
      sr <= '0;
    else if (load)
      sr <= data ^ {CHAR_W{inverse}};
    else
      sr <= sr << 1;
  end

  assign msb = sr[CHAR_W-1];

endmodule

// File: rtl/text_buffer_arbiter.sv
// Char RAM arbiter and glyph fetch pipeline for an 80x30 text screen.
// Optional blinking cursor enabled by defining TEXT_CURSOR_EN.
module text_buffer_arbiter
  import text_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [9:0]         h_count,
  input  logic [9:0]         v_count,
  input  logic               hsync_in,
  input  logic               vsync_in,
`ifdef TEXT_CURSOR_EN
  input  logic [CELL_AW-1:0] cursor_addr,
  input  logic               cursor_en,
`endif
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [CELL_AW-1:0] host_addr,
  input  logic [7:0]         host_data,
  output logic               wr_drop,
  output logic [CELL_AW-1:0] ram_addr,
  output logic               ram_we,
  output logic [7:0]         ram_wdata,
  input  logic [7:0]         ram_rdata,
  output logic [FONT_AW-1:0] font_addr,
  input  logic [7:0]         font_data,
  output logic               pixel_on,
  output logic               hsync_out,
  output logic               vsync_out
);

  logic [10:0]        t_sum;
  logic [10:0]        t;
  logic [9:0]         line;
  logic               slot;
  logic [CELL_AW-1:0] fetch_addr;
  logic               accept;
  logic               active;
  logic               cursor_hit;

  logic               fetch_v1, fetch_v2;
  logic [LINE_W-1:0]  glyph_line;
  logic               hit_q;
  logic               inv_q;
  logic [CELL_AW-1:0] addr_q;
  logic [7:0]         wdata_q;
  logic               sr_msb;

  // Fetch runs FETCH_LEAD pixels ahead, wrapping into the next line/frame.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
  always_comb begin
    t_sum = {1'b0, h_count} + 11'(FETCH_LEAD);
    t     = t_sum;
    line  = v_count;
    if (t_sum >= 11'(H_TOTAL)) begin
      t    = t_sum - 11'(H_TOTAL);
      line = (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
    end
  end

  assign slot       = (h_count[2:0] == 3'd5) && (t < 11'(H_ACTIVE)) && (line < 10'(V_ACTIVE));
  assign fetch_addr = cell_index(line[8:4], t[9:3]);
  assign active     = (h_count < 10'(H_ACTIVE)) && (v_count < 10'(V_ACTIVE));

  assign host_ready = !reset && !slot;
  assign accept     = host_valid && host_ready;
  assign wr_drop    = accept && (host_addr >= CELL_AW'(CELLS));
  assign ram_we     = accept && !wr_drop;

  // Display fetch wins the port; otherwise an accepted host write; otherwise hold.
  always_comb begin
    ram_addr  = addr_q;
    ram_wdata = wdata_q;
    if (slot) begin
      ram_addr = fetch_addr;
    end else if (accept) begin
      ram_addr  = host_addr;
      ram_wdata = host_data;
    end
  end

  assign font_addr = {ram_rdata[6:0], glyph_line};

`ifdef TEXT_CURSOR_EN
  logic [4:0] frame_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      frame_cnt <= '0;
    else if (h_count == 10'd0 && v_count == 10'd0)
      frame_cnt <= frame_cnt + 5'd1;
  end

  assign cursor_hit = cursor_en && frame_cnt[4] && (fetch_addr == cursor_addr);
`else
  assign cursor_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_v1   <= 1'b0;
      fetch_v2   <= 1'b0;
      glyph_line <= '0;
      hit_q      <= 1'b0;
      inv_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      pixel_on   <= 1'b0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
    end else begin
      fetch_v1 <= slot;
      fetch_v2 <= fetch_v1;
      if (slot) begin
        glyph_line <= line[LINE_W-1:0];
        hit_q      <= cursor_hit;
      end
      if (fetch_v1)
        inv_q <= ram_rdata[7] ^ hit_q;
      addr_q    <= ram_addr;
      wdata_q   <= ram_wdata;
      pixel_on  <= active && sr_msb;
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

  glyph_shifter u_shifter (
    .clk     (clk),
    .reset   (reset),
    .load    (fetch_v2),
    .data    (font_data),
    .inverse (inv_q),
    .msb     (sr_msb)
  );

endmodule

// File: tb/tb_text_buffer_arbiter.sv
// Directed bench for text_buffer_arbiter with a char RAM model and a font stub
// (glyph 0 blank, any other glyph row = 8'hA5). Define TEXT_CURSOR_EN for the cursor test.
module tb_text_buffer_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_count, v_count;
  logic        hsync_in, vsync_in;
  logic        host_valid, host_ready;
  logic [11:0] host_addr;
  logic [7:0]  host_data;
  logic        wr_drop;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic        pixel_on, hsync_out, vsync_out;
`ifdef TEXT_CURSOR_EN
  logic [11:0] cursor_addr;
  logic        cursor_en;
`endif

  logic [7:0] mem [0:4095] = '{default: 8'h00};

  int n_checks = 0;
  int n_pass   = 0;
  int we_count, stall_count;
  bit tally = 1'b0;

  always #5 clk = ~clk;

  assign hsync_in = !(h_count >= 10'd656 && h_count < 10'd752);
  assign vsync_in = !(v_count >= 10'd490 && v_count < 10'd492);

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
    font_data <= (font_addr[10:4] == 7'd0) ? 8'h00 : 8'hA5;
  end

  text_buffer_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .h_count     (h_count),
    .v_count     (v_count),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
`ifdef TEXT_CURSOR_EN
    .cursor_addr (cursor_addr),
    .cursor_en   (cursor_en),
`endif
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_addr   (host_addr),
    .host_data   (host_data),
    .wr_drop     (wr_drop),
    .ram_addr    (ram_addr),
    .ram_we      (ram_we),
    .ram_wdata   (ram_wdata),
    .ram_rdata   (ram_rdata),
    .font_addr   (font_addr),
    .font_data   (font_data),
    .pixel_on    (pixel_on),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  // Advance one pixel clock; returns 2 time units after the edge with new counts applied.
  task automatic step();
    if (tally) begin
      if (ram_we) we_count++;
      if (!host_ready) stall_count++;
    end
    @(posedge clk);
    #1;
    if (h_count == 10'd799) begin
      h_count = 10'd0;
      v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count = h_count + 10'd1;
    end
    #1;
  endtask

  task automatic set_pos(input int v, input int h);
    v_count = 10'(v);
    h_count = 10'(h);
    #1;
  endtask

  task automatic goto_pos(input int v, input int h, input int budget);
    int n = 0;
    while ((h_count != 10'(h) || v_count != 10'(v)) && n < budget) begin
      step();
      n++;
    end
    check("reach_pos", {12'd0, v_count, h_count}, {12'd0, 10'(v), 10'(h)});
  endtask

  // Collect the 8 pixels of the cell starting at (v,h), starting early enough to fetch it.
  task automatic show_byte(input int v, input int h, output logic [7:0] b);
    int lin;
    lin = v * 800 + h - 12;
    if (lin < 0) lin += 525 * 800;
    set_pos(lin / 800, lin % 800);
    goto_pos(v, h, 20);
    for (int i = 0; i < 8; i++) begin
      step();
      b[7-i] = pixel_on;
    end
  endtask

  task automatic host_write(input logic [11:0] a, input logic [7:0] d);
    int n = 0;
    host_addr  = a;
    host_data  = d;
    host_valid = 1'b1;
    #1;
    while (!host_ready && n < 4) begin
      step();
      n++;
    end
    check("host_accept", {31'd0, host_ready}, 32'd1);
    step();
    host_valid = 1'b0;
    #1;
  endtask

  initial begin
    logic [7:0] b;
    int bad;
    reset      = 1'b1;
    host_valid = 1'b1;
    host_addr  = 12'd5;
    host_data  = 8'h11;
`ifdef TEXT_CURSOR_EN
    cursor_addr = 12'd0;
    cursor_en   = 1'b0;
`endif
    set_pos(491, 700);
    step();
    step();
    check("rst_pixel", {31'd0, pixel_on}, 32'd0);
    check("rst_hsync", {31'd0, hsync_out}, 32'd1);
    check("rst_vsync", {31'd0, vsync_out}, 32'd1);
    check("rst_ready", {31'd0, host_ready}, 32'd0);
    check("rst_we", {31'd0, ram_we}, 32'd0);
    check("rst_drop", {31'd0, wr_drop}, 32'd0);
    host_valid = 1'b0;
    reset      = 1'b0;

    // Sync pass-through with one cycle delay.
    set_pos(490, 655);
    step();
    check("hsync_before", {31'd0, hsync_out}, 32'd1);
    check("vsync_delayed", {31'd0, vsync_out}, 32'd0);
    step();
    check("hsync_after", {31'd0, hsync_out}, 32'd0);

    // Host writes during vertical blank.
    set_pos(500, 100);
    host_valid = 1'b1;
    host_addr  = 12'd0;
    host_data  = 8'h41;
    #1;
    check("wr0_ready", {31'd0, host_ready}, 32'd1);
    check("wr0_we", {31'd0, ram_we}, 32'd1);
    check("wr0_addr", {20'd0, ram_addr}, 32'd0);
    check("wr0_data", {24'd0, ram_wdata}, 32'h41);
    step();
    host_valid = 1'b0;
    host_write(12'd81, 8'hC1);
    host_write(12'd37, 8'h41);

    host_valid = 1'b1;
    host_addr  = 12'd2400;
    host_data  = 8'h55;
    #1;
    check("drop_pulse", {31'd0, wr_drop}, 32'd1);
    check("drop_we", {31'd0, ram_we}, 32'd0);
    check("drop_ready", {31'd0, host_ready}, 32'd1);
    step();
    host_valid = 1'b0;
    #1;
    check("drop_clear", {31'd0, wr_drop}, 32'd0);
    step();
    check("idle_addr_hold", {20'd0, ram_addr}, 32'd2400);
    check("idle_we", {31'd0, ram_we}, 32'd0);

    // Host request landing on a fetch slot: one-cycle stall.
    set_pos(100, 5);
    host_valid = 1'b1;
    host_addr  = 12'd2399;
    host_data  = 8'h20;
    #1;
    check("slot_ready", {31'd0, host_ready}, 32'd0);
    check("slot_we", {31'd0, ram_we}, 32'd0);
    check("slot_addr", {20'd0, ram_addr}, 32'd481);
    step();
    check("stall_ready", {31'd0, host_ready}, 32'd1);
    check("stall_we", {31'd0, ram_we}, 32'd1);
    check("stall_addr", {20'd0, ram_addr}, 32'd2399);

    // host_valid held for a whole line.
    set_pos(100, 0);
    we_count    = 0;
    stall_count = 0;
    bad         = 0;
    tally       = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if (host_ready == ((h_count % 8 == 5) && (h_count <= 10'd629 || h_count == 10'd797))) bad++;
      step();
    end
    tally      = 1'b0;
    host_valid = 1'b0;
    check("line_ready_pattern", bad, 0);
    check("line_stalls", stall_count, 80);
    check("line_writes", we_count, 720);

    // Wrap fetch of cell 0 at h=797 of the last line.
    set_pos(524, 797);
    check("wrap_slot_ready", {31'd0, host_ready}, 32'd0);
    check("wrap_slot_addr", {20'd0, ram_addr}, 32'd0);

    show_byte(0, 0, b);
    check("cell0_line0", {24'd0, b}, 32'hA5);
    show_byte(0, 8, b);
    check("cell1_blank", {24'd0, b}, 32'h00);
    show_byte(16, 8, b);
    check("cell81_inverse", {24'd0, b}, 32'h5A);

    set_pos(21, 5);
    check("fetch81_addr", {20'd0, ram_addr}, 32'd81);
    step();
    check("fetch81_font", {21'd0, font_addr}, 32'h415);

    // Reset mid-line while cell 37 is on screen.
    set_pos(0, 280);
    goto_pos(0, 298, 30);
    reset = 1'b1;
    #1;
    check("midrst_ready", {31'd0, host_ready}, 32'd0);
    step();
    check("midrst_pixel", {31'd0, pixel_on}, 32'd0);
    check("midrst_hsync", {31'd0, hsync_out}, 32'd1);
    check("midrst_vsync", {31'd0, vsync_out}, 32'd1);
    reset = 1'b0;
    step();
    step();
    step();
    check("midrst_blank301", {31'd0, pixel_on}, 32'd0);
    step();
    step();
    check("midrst_blank303", {31'd0, pixel_on}, 32'd0);
    show_byte(1, 0, b);
    check("after_rst_cell0", {24'd0, b}, 32'hA5);
    show_byte(1, 296, b);
    check("after_rst_cell37", {24'd0, b}, 32'hA5);

`ifdef TEXT_CURSOR_EN
    reset = 1'b1;
    set_pos(500, 0);
    step();
    reset       = 1'b0;
    cursor_addr = 12'd0;
    cursor_en   = 1'b1;
    show_byte(0, 0, b);
    check("cursor_frame0", {24'd0, b}, 32'hA5);
    for (int i = 0; i < 15; i++) begin
      set_pos(0, 0);
      step();
    end
    show_byte(0, 0, b);
    check("cursor_frame16", {24'd0, b}, 32'h5A);
    for (int i = 0; i < 15; i++) begin
      set_pos(0, 0);
      step();
    end
    show_byte(0, 0, b);
    check("cursor_frame32", {24'd0, b}, 32'hA5);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
